// File: rtl/m68040_bus_master.sv
// 68040-style local bus initiator: turns one agent request into a sequenced bus
// transfer (single, line burst, or burst-inhibited line) with nTA/nTEA/timeout handling.
module m68040_bus_master #(
  parameter int         TIMEOUT = 64,
  parameter logic [2:0] TM_VAL  = 3'b001
) (
  input  logic         clk,
  input  logic         nRESET,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [31:0]  req_addr,
  input  logic         req_rw,
  input  logic [1:0]   req_siz,
  input  logic [127:0] req_wdata,
  output logic [31:0]  rd_data,
  output logic         rd_valid,
  output logic [1:0]   rd_beat,
  output logic         done,
  output logic         err,
  output logic [31:0]  A,
  output logic [1:0]   TT,
  output logic [2:0]   TM,
  output logic [1:0]   SIZ,
  output logic         RW,
  output logic         nTS,
  input  logic [31:0]  D_in,
  output logic [31:0]  D_out,
  output logic         D_oe,
  input  logic         nTA,
  input  logic         nTEA,
  input  logic         nTBI
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] WAIT     = 3'd2;
  localparam logic [2:0] ERR_DONE = 3'd3;
  localparam logic [2:0] OK_DONE  = 3'd4;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  logic [2:0]   state_r;
  logic [31:0]  addr_r;
  logic         rw_r;
  logic         line_r;
  logic         tbi_r;
  logic [127:0] wdata_r;
  logic [1:0]   beat_r;
  logic [7:0]   cnt_r;
  logic [1:0]   base_s;
  logic [1:0]   idx_s;
  logic [1:0]   idx_next_s;

  function automatic logic [31:0] lane(input logic [127:0] d, input logic [1:0] i);
    logic [31:0] r;
    case (i)
      2'd0:    r = d[31:0];
      2'd1:    r = d[63:32];
      2'd2:    r = d[95:64];
      2'd3:    r = d[127:96];
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  assign TT = 2'b00;
  assign TM = TM_VAL;

  // Line beats walk the 16-byte line starting at the requested longword, wrapping.
  always_comb begin
    base_s = 2'b00;
    if (line_r) begin
      base_s = addr_r[3:2];
    end else begin
      base_s = 2'b00;
    end
    idx_s      = base_s + beat_r;
    idx_next_s = idx_s + 2'd1;
  end

  // Transfer sequencer with registered bus and agent-side outputs.
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_r   <= IDLE;
      addr_r    <= 32'd0;
      rw_r      <= 1'b1;
      line_r    <= 1'b0;
      tbi_r     <= 1'b0;
      wdata_r   <= 128'd0;
      beat_r    <= 2'd0;
      cnt_r     <= 8'd0;
      req_ready <= 1'b1;
      rd_data   <= 32'd0;
      rd_valid  <= 1'b0;
      rd_beat   <= 2'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      A         <= 32'd0;
      SIZ       <= 2'b00;
      RW        <= 1'b1;
      nTS       <= 1'b1;
      D_out     <= 32'd0;
      D_oe      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            addr_r    <= req_addr;
            rw_r      <= req_rw;
            line_r    <= (req_siz == 2'b11);
            tbi_r     <= 1'b0;
            wdata_r   <= req_wdata;
            beat_r    <= 2'd0;
            A         <= req_addr;
            SIZ       <= req_siz;
            RW        <= req_rw;
            nTS       <= 1'b0;
            req_ready <= 1'b0;
            state_r   <= START;
          end else begin
            req_ready <= 1'b1;
          end
        end
        START: begin
          nTS     <= 1'b1;
          cnt_r   <= 8'd0;
          D_oe    <= ~rw_r;
          D_out   <= lane(wdata_r, idx_s);
          state_r <= WAIT;
        end
        WAIT: begin
          if (!nTEA) begin
            D_oe    <= 1'b0;
            state_r <= ERR_DONE;
          end else if (!nTA) begin
            cnt_r <= 8'd0;
            if (rw_r) begin
              rd_valid <= 1'b1;
              rd_data  <= D_in;
              rd_beat  <= idx_s;
            end
            if (!line_r || (beat_r == 2'd3)) begin
              D_oe    <= 1'b0;
              state_r <= OK_DONE;
            end else begin
              beat_r <= beat_r + 2'd1;
              D_out  <= lane(wdata_r, idx_next_s);
              // Burst inhibit on the first beat turns the rest into single longword cycles.
              if (tbi_r || ((beat_r == 2'd0) && !nTBI)) begin
                tbi_r   <= 1'b1;
                A       <= {addr_r[31:4], idx_next_s, 2'b00};
                SIZ     <= 2'b00;
                nTS     <= 1'b0;
                D_oe    <= 1'b0;
                state_r <= START;
              end
            end
          end else if (cnt_r == TO_LAST) begin
            D_oe    <= 1'b0;
            state_r <= ERR_DONE;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        ERR_DONE: begin
          done      <= 1'b1;
          err       <= 1'b1;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        OK_DONE: begin
          done      <= 1'b1;
          err       <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          nTS     <= 1'b1;
          D_oe    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
